perf_counter_bank: RTL and testbench
====================================

// Module: perf_counter_bank
// PURPOSE
//   Parametrised bank of NCH free-running event counters for CPU performance
//   monitoring: cycles, retired instructions, stalls, branches and so on.
//   Each channel counts single-cycle event pulses. Channels support:
//   - global enable and synchronous clear;
//   - software preload of one channel per cycle;
//   - wrap or saturate overflow mode, with sticky overflow flags;
//   - an atomic snapshot of all channels into shadow registers.
//   Sits beside the CPU core. The debug/MMIO read path samples the shadow
//   registers through rd_sel.
// PARAMETERS
//   WIDTH     32  counter width in bits (>=2)
//   NCH        4  number of channels (>=1); tie evt[0]=1 for a cycle counter
//   SATURATE   0  0: wrap to 0 on overflow; 1: hold at all-ones
//   SELW       2  select width; must satisfy 2**SELW >= NCH
// PORTS
//   clk        in   1           rising-edge clock
//   rst        in   1           asynchronous, active-high reset
//   en         in   1           global count enable (gates evt only)
//   evt        in   NCH         per-channel event pulse, +1 per high cycle
//   clr        in   1           synchronous clear of all counters and flags
//   wr_en      in   1           preload strobe
//   wr_sel     in   SELW        channel to preload
//   wr_data    in   WIDTH       preload value
//   snap       in   1           copy all live counters into shadow regs
//   ovf_clr    in   1           clear all sticky overflow flags
//   rd_sel     in   SELW        shadow channel to read
//   rd_data    out  WIDTH       shadow[rd_sel], combinational
//   cnt0       out  WIDTH       live value of channel 0
//   ovf        out  NCH         sticky overflow flags
// BEHAVIOUR
//   - Reset (async, rst=1): all live counters, shadows and ovf go to 0.
//     Therefore rd_data=0, cnt0=0 and ovf=0 immediately, with no clock
//     needed. Reset mid-count discards all state.
//   - Per channel i, per rising edge, in priority order:
//     1. clr: live[i]<=0 and ovf[i]<=0; a same-cycle wr_en or evt is ignored.
//     2. wr_en && wr_sel==i: live[i]<=wr_data; evt[i] that cycle is dropped,
//        and ovf[i] is unchanged.
//     3. en && evt[i]: increment.
//        - live[i] != all-ones: live[i]<=live[i]+1.
//        - live[i] == all-ones, SATURATE=0: live[i]<=0 and ovf[i]<=1.
//        - live[i] == all-ones, SATURATE=1: live[i] holds and ovf[i]<=1.
//     4. Otherwise: hold.
//   - ovf_clr: ovf<=0 on the edge, unless the same edge sets ovf[i]
//     (set wins). clr overrides everything.
//   - Latency: an event sampled at edge k is visible on cnt0 and live[i]
//     after edge k (1 cycle). en=0 freezes the counts; wr_en and clr still
//     act.
//   - snap: every shadow[i]<=live[i], taking the value before this edge's
//     update. Snapshot is atomic across channels. With snap and clr in the
//     same cycle, the shadows get the pre-clear values. Shadows change only
//     on snap or rst.
//   - rd_data=shadow[rd_sel], with no registered delay. rd_sel>=NCH or
//     wr_sel>=NCH: rd_data=0 and the write is ignored.
//   - All arithmetic is unsigned, modulo 2**WIDTH. There is no carry
//     between channels.
// TESTING  (WIDTH=8, NCH=4, SELW=2 unless noted)
//   1. rst pulse mid-count with en=1, evt=4'b0001 for 10 cycles
//      -> cnt0=0 during rst; 10 cycles after release cnt0=10 and ovf=0.
//   2. Wrap: wr ch1=8'hFE, then 3 evt[1] pulses -> live1 goes FF, 00, 01;
//      ovf[1] rises on the FF->00 edge and stays 1 until ovf_clr.
//   3. Saturate (SATURATE=1): preload ch2=8'hFF, then evt[2] -> stays FF
//      with ovf[2]=1. ovf_clr together with another evt[2] -> ovf[2] stays 1.
//   4. Snapshot: counting at ch0=37, pulse snap with evt[0]=1
//      -> shadow0=37 while live ch0=38. rd_sel=0 gives rd_data=37 in the
//      same cycle. rd_sel=3 gives ch3's pre-snap value.
//   5. Priority: clr+wr_en+evt[3] in one cycle -> ch3=0 and ovf=0.
//      Then wr_en(ch3=8'h50)+evt[3] -> ch3=8'h50 (event dropped).
//   6. en=0 with evt=4'hF for 5 cycles -> all counts unchanged, while
//      wr_en preload still applies.

Source files
------------

// File: rtl/perf_counter_bank.sv
// Bank of NCH event counters with preload, wrap/saturate overflow handling,
// sticky overflow flags and an atomic shadow snapshot read through rd_sel.
module perf_counter_bank #(
    parameter int WIDTH    = 32,
    parameter int NCH      = 4,
    parameter int SATURATE = 0,
    parameter int SELW     = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [NCH-1:0]   evt,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [SELW-1:0]  wr_sel,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             snap,
    input  logic             ovf_clr,
    input  logic [SELW-1:0]  rd_sel,
    output logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] cnt0,
    output logic [NCH-1:0]   ovf
);

    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    logic [WIDTH-1:0] live_vec   [NCH];
    logic [WIDTH-1:0] shadow_vec [NCH];

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
            logic [WIDTH-1:0] live_q, live_d;
            logic [WIDTH-1:0] shadow_q;
            logic             ovf_q, ovf_d;
            logic             wr_hit;
            logic             ovf_set;

            // Selects at or above NCH match no channel, so such writes vanish.
            assign wr_hit = wr_en && (32'(wr_sel) == gi);

            always_comb begin
                live_d  = live_q;
                ovf_set = 1'b0;
                if (clr) begin
                    live_d = '0;
                end else if (wr_hit) begin
                    live_d = wr_data;
                end else if (en && evt[gi]) begin
                    if (live_q != ALL_ONES) begin
                        live_d = live_q + 1'b1;
                    end else begin
                        ovf_set = 1'b1;
                        live_d  = (SATURATE != 0) ? ALL_ONES : '0;
                    end
                end
            end

            // A new overflow on this edge beats a concurrent flag clear.
            always_comb begin
                ovf_d = ovf_q;
                if (clr) begin
                    ovf_d = 1'b0;
                end else if (ovf_set) begin
                    ovf_d = 1'b1;
                end else if (ovf_clr) begin
                    ovf_d = 1'b0;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    live_q   <= '0;
                    shadow_q <= '0;
                    ovf_q    <= 1'b0;
                end else begin
                    live_q <= live_d;
                    ovf_q  <= ovf_d;
                    if (snap) begin
                        shadow_q <= live_q;
                    end
                end
            end

            assign live_vec[gi]   = live_q;
            assign shadow_vec[gi] = shadow_q;
            assign ovf[gi]        = ovf_q;
        end
    endgenerate

    assign cnt0 = live_vec[0];

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NCH; i++) begin
            if (32'(rd_sel) == i) begin
                rd_data = shadow_vec[i];
            end
        end
    end

endmodule

// File: tb/tb_perf_counter_bank.sv
// Bench for perf_counter_bank: a wrapping and a saturating instance share
// stimulus; a behavioural model feeds a scoreboard, plus directed checks.
module tb_perf_counter_bank;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] evt;
    logic       clr;
    logic       wr_en;
    logic [1:0] wr_sel;
    logic [7:0] wr_data;
    logic       snap;
    logic       ovf_clr;
    logic [1:0] rd_sel;
    logic [7:0] rd_a, rd_b, cnt0_a, cnt0_b;
    logic [3:0] ovf_a, ovf_b;

    always #5 clk = ~clk;

    perf_counter_bank #(.WIDTH(8), .NCH(4), .SATURATE(0), .SELW(2)) dut_wrap (
        .clk(clk), .rst(rst), .en(en), .evt(evt), .clr(clr), .wr_en(wr_en),
        .wr_sel(wr_sel), .wr_data(wr_data), .snap(snap), .ovf_clr(ovf_clr),
        .rd_sel(rd_sel), .rd_data(rd_a), .cnt0(cnt0_a), .ovf(ovf_a)
    );

    perf_counter_bank #(.WIDTH(8), .NCH(4), .SATURATE(1), .SELW(2)) dut_sat (
        .clk(clk), .rst(rst), .en(en), .evt(evt), .clr(clr), .wr_en(wr_en),
        .wr_sel(wr_sel), .wr_data(wr_data), .snap(snap), .ovf_clr(ovf_clr),
        .rd_sel(rd_sel), .rd_data(rd_b), .cnt0(cnt0_b), .ovf(ovf_b)
    );

    typedef struct {
        logic [7:0] cnt0_a, cnt0_b, rd_a, rd_b;
        logic [3:0] ovf_a, ovf_b;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_txn    = 0;

    // Index 0 models the wrapping instance, index 1 the saturating one.
    logic [7:0] m_live [2][4];
    logic [7:0] m_sh   [2][4];
    logic [3:0] m_ovf  [2];

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            m_ovf[s] = '0;
            for (int i = 0; i < 4; i++) begin
                m_live[s][i] = '0;
                m_sh[s][i]   = '0;
            end
        end
    endtask

    task automatic model_step();
        logic set;
        if (rst) begin
            model_reset();
            return;
        end
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 4; i++) begin
                if (snap) m_sh[s][i] = m_live[s][i];
                if (clr) begin
                    m_live[s][i] = 8'h00;
                    m_ovf[s][i]  = 1'b0;
                end else begin
                    set = 1'b0;
                    if (wr_en && wr_sel == 2'(i)) begin
                        m_live[s][i] = wr_data;
                    end else if (en && evt[i]) begin
                        if (m_live[s][i] == 8'hFF) begin
                            set = 1'b1;
                            m_live[s][i] = (s == 1) ? 8'hFF : 8'h00;
                        end else begin
                            m_live[s][i] = m_live[s][i] + 8'h01;
                        end
                    end
                    if (set) m_ovf[s][i] = 1'b1;
                    else if (ovf_clr) m_ovf[s][i] = 1'b0;
                end
            end
        end
    endtask

    // One clock: model predicts, expectation queued, DUT sampled 1 ns after the edge.
    task automatic cycle();
        exp_t e;
        model_step();
        e.cnt0_a = m_live[0][0];
        e.cnt0_b = m_live[1][0];
        e.ovf_a  = m_ovf[0];
        e.ovf_b  = m_ovf[1];
        e.rd_a   = m_sh[0][rd_sel];
        e.rd_b   = m_sh[1][rd_sel];
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        n_txn++;
        $display("txn %0d: cnt0=%h/%h ovf=%h/%h rd[%0d]=%h/%h", n_txn,
                 cnt0_a, cnt0_b, ovf_a, ovf_b, rd_sel, rd_a, rd_b);
        check_eq("sb_cnt0_wrap", cnt0_a, e.cnt0_a);
        check_eq("sb_cnt0_sat",  cnt0_b, e.cnt0_b);
        check_eq("sb_ovf_wrap",  ovf_a,  e.ovf_a);
        check_eq("sb_ovf_sat",   ovf_b,  e.ovf_b);
        check_eq("sb_rd_wrap",   rd_a,   e.rd_a);
        check_eq("sb_rd_sat",    rd_b,   e.rd_b);
    endtask

    task automatic write(input logic [1:0] sel, input logic [7:0] data);
        wr_en = 1'b1; wr_sel = sel; wr_data = data;
        cycle();
        wr_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; evt = '0; clr = 1'b0; wr_en = 1'b0; wr_sel = '0;
        wr_data = '0; snap = 1'b0; ovf_clr = 1'b0; rd_sel = '0;
        model_reset();
        #3;
        check_eq("rst_cnt0", cnt0_a, 8'h00);
        check_eq("rst_ovf",  ovf_a,  4'h0);
        check_eq("rst_rd",   rd_b,   8'h00);
        @(negedge clk);
        rst = 1'b0;

        // Asynchronous reset in the middle of counting
        en = 1'b1; evt = 4'b0001;
        repeat (4) cycle();
        rst = 1'b1;
        model_reset();
        #1;
        check_eq("t1_cnt0_in_rst", cnt0_a, 8'h00);
        repeat (2) cycle();
        @(negedge clk);
        rst = 1'b0;
        repeat (10) cycle();
        check_eq("t1_cnt0_after", cnt0_a, 8'd10);
        check_eq("t1_ovf_after",  ovf_a,  4'h0);

        // Wrap on channel 1, observed through per-cycle snapshots
        evt = 4'b0000;
        write(2'd1, 8'hFE);
        evt = 4'b0010; snap = 1'b1; rd_sel = 2'd1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            check_eq("t2_ovf1_step", ovf_a[1], (k >= 1) ? 1 : 0);
        end
        evt = 4'b0000;
        cycle();
        snap = 1'b0;
        check_eq("t2_live1_wrap", rd_a, 8'h01);
        check_eq("t2_live1_sat",  rd_b, 8'hFF);
        check_eq("t2_ovf1_held",  ovf_a[1], 1'b1);
        ovf_clr = 1'b1;
        cycle();
        ovf_clr = 1'b0;
        check_eq("t2_ovf_cleared", ovf_a, 4'h0);

        // Saturate on channel 2; set beats a concurrent ovf_clr
        write(2'd2, 8'hFF);
        evt = 4'b0100;
        cycle();
        check_eq("t3_ovf2_sat", ovf_b[2], 1'b1);
        evt = 4'b0000; snap = 1'b1; rd_sel = 2'd2;
        cycle();
        snap = 1'b0;
        check_eq("t3_live2_sat",  rd_b, 8'hFF);
        check_eq("t3_live2_wrap", rd_a, 8'h00);
        ovf_clr = 1'b1; evt = 4'b0100;
        cycle();
        ovf_clr = 1'b0; evt = 4'b0000;
        check_eq("t3_set_wins",   ovf_b[2], 1'b1);
        check_eq("t3_clr_wrap",   ovf_a[2], 1'b0);

        // Snapshot takes pre-edge values; rd_data follows rd_sel combinationally
        write(2'd3, 8'h21);
        write(2'd0, 8'd35);
        evt = 4'b0001;
        repeat (2) cycle();
        snap = 1'b1; rd_sel = 2'd0;
        cycle();
        snap = 1'b0; evt = 4'b0000;
        check_eq("t4_shadow0", rd_a,   8'd37);
        check_eq("t4_live0",   cnt0_a, 8'd38);
        rd_sel = 2'd3;
        #1;
        check_eq("t4_shadow3", rd_a, 8'h21);

        // clr outranks write and event; write outranks event
        clr = 1'b1; wr_en = 1'b1; wr_sel = 2'd3; wr_data = 8'hAA; evt = 4'b1000;
        cycle();
        clr = 1'b0;
        check_eq("t5_clr_cnt0",    cnt0_a, 8'h00);
        check_eq("t5_clr_ovf_wrap", ovf_a, 4'h0);
        check_eq("t5_clr_ovf_sat",  ovf_b, 4'h0);
        wr_data = 8'h50;
        cycle();
        wr_en = 1'b0; evt = 4'b0000; snap = 1'b1;
        cycle();
        snap = 1'b0;
        check_eq("t5_wr_drops_evt", rd_a, 8'h50);

        // en=0 freezes counting but preload still lands
        write(2'd0, 8'h05);
        en = 1'b0; evt = 4'hF;
        write(2'd1, 8'h77);
        repeat (4) cycle();
        check_eq("t6_frozen_cnt0", cnt0_a, 8'h05);
        evt = 4'h0; snap = 1'b1; rd_sel = 2'd1;
        cycle();
        snap = 1'b0;
        check_eq("t6_preload1", rd_a, 8'h77);
        rd_sel = 2'd2;
        #1;
        check_eq("t6_frozen2", rd_a, 8'h00);

        // Random traffic, biased toward the top of the range to hit overflow
        for (int n = 0; n < 80; n++) begin
            en      = ($urandom_range(0, 7) != 0);
            evt     = 4'($urandom);
            clr     = ($urandom_range(0, 19) == 0);
            wr_en   = ($urandom_range(0, 3) == 0);
            wr_sel  = 2'($urandom);
            wr_data = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(248, 255)) : 8'($urandom);
            snap    = ($urandom_range(0, 1) != 0);
            ovf_clr = ($urandom_range(0, 7) == 0);
            rd_sel  = 2'($urandom);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
